// File: rtl/forward_pkg.sv
// Shared definitions for the operand-forwarding unit: register index width
// and the encoding of the per-operand forwarding select.
package forward_pkg;

  // Width of a register index (8 architectural registers).
  localparam int REG_W = 3;

  // Forwarding select as seen by the ALU operand muxes.
  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_MEM = 2'd0;  // take the MEM-stage result
  localparam fwd_sel_t FWD_WB  = 2'd1;  // take the WB-stage result
  localparam fwd_sel_t FWD_REG = 2'd2;  // take the register-file value

endpackage : forward_pkg

// File: rtl/forward_sel.sv
// Combinational forwarding decision for a single source operand.
// The MEM stage holds the youngest in-flight result, so it wins over WB.
// Index 0 is matched like any other index, and no valid qualification is
// applied at this level.
module forward_sel
  import forward_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rdMEM,
  input  logic [REG_W-1:0] rdWB,
  output fwd_sel_t         sel
);

  // Priority compare: MEM hit, else WB hit, else register file.
  always_comb begin
    // NOTE: default assignment first, so every path drives sel and no latch is inferred.
    sel = FWD_REG;
    if (rs == rdMEM) begin
      sel = FWD_MEM;
    end else if (rs == rdWB) begin
      sel = FWD_WB;
    end
  end

endmodule : forward_sel

// File: rtl/forward_unit.sv
// Pipeline operand-forwarding selector. Compares both source indices of the
// instruction entering execute with the MEM and WB destination indices and
// registers one select per operand (latency one cycle).
module forward_unit
  import forward_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rdMEM,
  input  logic [REG_W-1:0] rdWB,
  output logic [1:0]       fwd1,
  output logic [1:0]       fwd2
);

  fwd_sel_t sel1;
  fwd_sel_t sel2;

  // rd is carried on the interface for symmetry only; it never affects a select.
  logic unused_rd;
  assign unused_rd = ^rd;

  forward_sel u_sel1 (
    .rs    (rs1),
    .rdMEM (rdMEM),
    .rdWB  (rdWB),
    .sel   (sel1)
  );

  forward_sel u_sel2 (
    .rs    (rs2),
    .rdMEM (rdMEM),
    .rdWB  (rdWB),
    .sel   (sel2)
  );

  // Output registers: reset forces register-file selects, otherwise capture the compare.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state.
    if (reset) begin
      fwd1 <= FWD_REG;
      fwd2 <= FWD_REG;
    end else begin
      fwd1 <= sel1;
      fwd2 <= sel2;
    end
  end

endmodule : forward_unit

// File: tb/tb_forward_unit.sv
// Directed and exhaustive self-checking bench for forward_unit.
module tb_forward_unit;
  import forward_pkg::*;

  logic             clk;
  logic             reset;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rdMEM;
  logic [REG_W-1:0] rdWB;
  logic [1:0]       fwd1;
  logic [1:0]       fwd2;

  int errors = 0;
  int checks = 0;

  forward_unit dut (
    .clk   (clk),
    .reset (reset),
    .rs1   (rs1),
    .rs2   (rs2),
    .rd    (rd),
    .rdMEM (rdMEM),
    .rdWB  (rdWB),
    .fwd1  (fwd1),
    .fwd2  (fwd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference priority rule for one operand.
  function automatic logic [1:0] ref_sel(input logic [2:0] rs,
                                         input logic [2:0] m,
                                         input logic [2:0] w);
    if (rs == m)      return 2'd0;
    else if (rs == w) return 2'd1;
    else              return 2'd2;
  endfunction

  task automatic check(input string tag, input logic [1:0] observed,
                       input logic [1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one vector, then wait for the capturing edge and settle past it.
  task automatic apply(input logic [2:0] a1, input logic [2:0] a2,
                       input logic [2:0] ad, input logic [2:0] am,
                       input logic [2:0] aw);
    rs1 = a1; rs2 = a2; rd = ad; rdMEM = am; rdWB = aw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rs1 = 3'd3; rs2 = 3'd0; rd = 3'd0; rdMEM = 3'd3; rdWB = 3'd0;
    #2;

    // Reset held for two edges while rs1 matches rdMEM.
    @(posedge clk); #1;
    check("reset_e1_fwd1", fwd1, 2'd2);
    check("reset_e1_fwd2", fwd2, 2'd2);
    @(posedge clk); #1;
    check("reset_e2_fwd1", fwd1, 2'd2);
    check("reset_e2_fwd2", fwd2, 2'd2);

    // First edge without reset loads the compare.
    reset = 1'b0;
    apply(3'd5, 3'd2, 3'd0, 3'd5, 3'd2);
    check("mem_hit_fwd1", fwd1, 2'd0);
    check("wb_hit_fwd2", fwd2, 2'd1);

    // Outputs hold between edges when inputs change (registered, not combinational).
    rs1 = 3'd1; rs2 = 3'd6; rdMEM = 3'd3; rdWB = 3'd7;
    #2;
    check("hold_fwd1", fwd1, 2'd0);
    check("hold_fwd2", fwd2, 2'd1);

    // Both stages match: MEM wins.
    apply(3'd4, 3'd4, 3'd0, 3'd4, 3'd4);
    check("prio_fwd1", fwd1, 2'd0);
    check("prio_fwd2", fwd2, 2'd0);

    // No hit; rd equal to rs1 is ignored.
    apply(3'd1, 3'd6, 3'd1, 3'd3, 3'd7);
    check("nohit_fwd1", fwd1, 2'd2);
    check("nohit_fwd2", fwd2, 2'd2);

    // Index 0 is not special.
    apply(3'd0, 3'd0, 3'd0, 3'd1, 3'd0);
    check("idx0_fwd1", fwd1, 2'd1);
    check("idx0_fwd2", fwd2, 2'd1);

    // rs2 hits MEM while rs1 hits WB: operands are independent.
    apply(3'd6, 3'd7, 3'd7, 3'd7, 3'd6);
    check("indep_fwd1", fwd1, 2'd1);
    check("indep_fwd2", fwd2, 2'd0);

    // Mid-stream reset discards the pending select, release reloads it.
    rs1 = 3'd2; rs2 = 3'd5; rdMEM = 3'd2; rdWB = 3'd5;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_fwd1", fwd1, 2'd2);
    check("midreset_fwd2", fwd2, 2'd2);
    reset = 1'b0;
    @(posedge clk); #1;
    check("release_fwd1", fwd1, 2'd0);
    check("release_fwd2", fwd2, 2'd1);

    // Exhaustive sweep of rs1/rs2/rd/rdMEM/rdWB, one vector per cycle.
    for (int i = 0; i < 32768; i++) begin
      logic [14:0] v;
      logic [1:0]  e1;
      logic [1:0]  e2;
      v  = 15'(i);
      e1 = ref_sel(v[14:12], v[5:3], v[2:0]);
      e2 = ref_sel(v[11:9],  v[5:3], v[2:0]);
      apply(v[14:12], v[11:9], v[8:6], v[5:3], v[2:0]);
      check("sweep_fwd1", fwd1, e1);
      check("sweep_fwd2", fwd2, e2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_forward_unit
